fetch_pc: RTL

Instruction-fetch front end of the venus pipeline; the direct consumer of the EX-stage branch unit's destination address and branch-enable outputs. Holds the program counter, issues in-order requests to instruction memory over a request/grant interface, and buffers returned words in a small FIFO toward decode. On a taken branch it redirects the PC, squashes buffered and in-flight wrong-path instructions, and resumes fetch at the target on the next cycle.

---
 rtl/fetch_pc.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fetch_pc.sv
// fetch_pc: instruction-fetch front end of the venus pipeline.
// Holds the PC, issues in-order requests over a request/grant interface,
// buffers returned words toward decode and squashes wrong-path work on a
// taken branch.
// Optional feature macro: VENUS_FETCH_ALIGN_EN -- forces redirect targets to
// word alignment and adds the align_err_o pulse output.
module fetch_pc #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_valid_i,
    input  logic        branch_en_i,
    input  logic [31:0] dest_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        inst_ready_i
`ifdef VENUS_FETCH_ALIGN_EN
    ,
    output logic        align_err_o
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
    logic [PTR_W-1:0] fifo_wr_q, fifo_rd_q;

    // PCs of granted requests still waiting for their response, oldest first
    logic [31:0]      if_pc_q [FIFO_DEPTH];
    logic [PTR_W-1:0] if_wr_q, if_rd_q;

    logic             redirect;
    logic             pop;
    logic             gnt_acc;
    logic             rvalid_acc;
    logic             drop_rsp;
    logic             push;
    logic [CNT_W:0]   credits_used;
    logic [31:0]      target;

    assign redirect = branch_valid_i & branch_en_i;

`ifdef VENUS_FETCH_ALIGN_EN
    logic align_err_q;

    assign target      = {dest_addr_i[31:2], 2'b00};
    assign align_err_o = align_err_q;

    // One-cycle flag after a redirect whose target was not word aligned
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= redirect & (dest_addr_i[1:0] != 2'b00);
        end
    end
`else
    assign target = dest_addr_i;
`endif

    // Credits count both outstanding requests and buffered words, so a
    // request is only issued when its response is guaranteed a FIFO slot.
    assign inst_valid_o = (fifo_cnt_q != '0) & ~redirect;
    assign pop          = inst_valid_o & inst_ready_i;
    assign credits_used = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q} - (CNT_W + 1)'(pop);
    assign imem_req_o   = ~rst_i & ~redirect & (credits_used < DEPTH_C);
    assign imem_addr_o  = pc_q;

    assign gnt_acc    = imem_req_o & imem_gnt_i;
    assign rvalid_acc = imem_rvalid_i & (out_cnt_q != '0);
    assign drop_rsp   = (drop_cnt_q != '0);
    assign push       = rvalid_acc & ~drop_rsp & ~redirect;

    assign inst_o = fifo_data_q[fifo_rd_q];
    assign pc_o   = fifo_pc_q[fifo_rd_q];

    // Next PC and counter values; a redirect marks every request still
    // outstanding after this cycle's response as wrong-path.
    always_comb begin
        pc_d       = pc_q;
        out_cnt_d  = out_cnt_q + CNT_W'(gnt_acc) - CNT_W'(rvalid_acc);
        drop_cnt_d = drop_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        if (redirect) begin
            pc_d       = target;
            drop_cnt_d = out_cnt_d;
            fifo_cnt_d = '0;
        end else begin
            if (gnt_acc) begin
                pc_d = pc_q + 32'd4;
            end
            drop_cnt_d = drop_cnt_q - CNT_W'(rvalid_acc & drop_rsp);
            fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State update: PC, counters, in-flight PC queue and instruction FIFO
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            fifo_cnt_q <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            if_wr_q    <= '0;
            if_rd_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
                if_pc_q[i]     <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;

            if (gnt_acc) begin
                if_pc_q[if_wr_q] <= pc_q;
                if_wr_q          <= if_wr_q + PTR_W'(1);
            end
            if (rvalid_acc) begin
                if_rd_q <= if_rd_q + PTR_W'(1);
            end

            if (redirect) begin
                fifo_wr_q <= '0;
                fifo_rd_q <= '0;
            end else begin
                if (push) begin
                    fifo_data_q[fifo_wr_q] <= imem_rdata_i;
                    fifo_pc_q[fifo_wr_q]   <= if_pc_q[if_rd_q];
                    fifo_wr_q              <= fifo_wr_q + PTR_W'(1);
                end
                if (pop) begin
                    fifo_rd_q <= fifo_rd_q + PTR_W'(1);
                end
            end
        end
    end

endmodule
